alu_wb_queue: RTL and testbench
===============================

Name: alu_wb_queue

Overview:
- Receiving end of the ALU result interface.
- Captures each valid ALU result together with the transaction ID carried in fu_data_i. Buffers results in a small in-order queue and presents them to the scoreboard writeback port with a valid/ready handshake.
- Decouples the single-cycle, non-stallable ALU from writeback-port arbitration. Sits between the ALU and the scoreboard writeback mux inside the execute stage.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width; derived, not overridable.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- flush_i  in  1  synchronous flush (mispredict/exception); discards all queued results.
- alu_valid_i  in  1  ALU result valid this cycle.
- alu_ready_o  out  1  queue can accept a result this cycle.
- fu_data_i  in  fu_data_t  operation bundle; only trans_id is used.
- alu_result_i  in  riscv::XLEN  ALU result.
- wb_valid_o  out  1  head entry valid.
- wb_ready_i  in  1  writeback port consumes the head entry.
- wb_trans_id_o  out  TRANS_ID_BITS  trans_id of the head entry.
- wb_result_o  out  riscv::XLEN  result of the head entry.
- usage_o  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset, asynchronous: read pointer 0, write pointer 0, count 0, storage cleared.
  - Outputs after reset: wb_valid_o=0, alu_ready_o=1, usage_o=0, wb_trans_id_o=0, wb_result_o=0.
- Push: occurs when alu_valid_i && alu_ready_o. Writes {fu_data_i.trans_id, alu_result_i} at the write pointer. The write pointer increments modulo DEPTH.
- Pop: occurs when wb_valid_o && wb_ready_i. The read pointer increments modulo DEPTH.
- Output timing:
  - wb_valid_o = (count != 0).
  - wb_trans_id_o and wb_result_o are driven directly from storage at the read pointer, with no combinational path from the inputs.
  - Minimum latency from push to wb_valid_o is 1 cycle; there is no bypass.
- Ready: alu_ready_o = (count != DEPTH). It does not depend on wb_ready_i, so there is no combinational ready path. A full queue refuses a push even when a pop occurs in the same cycle.
- Simultaneous push and pop (count between 1 and DEPTH-1): count is unchanged and both pointers advance.
- Push into an empty queue: the entry is visible on the wb_* outputs in the next cycle.
- Wrap-around: the pointers are log2(DEPTH) bits and wrap naturally. Full and empty are derived only from count, never from pointer equality.
- Flush:
  - Takes priority over push and pop in the same cycle. Pointers and count go to 0 at the next edge, and any push or pop in the flush cycle is discarded.
  - Storage contents need not be cleared, but wb_valid_o=0 from the next cycle.
- Overflow: alu_valid_i while alu_ready_o=0 is an upstream protocol violation. The result is dropped with no state change, and an assertion fires in simulation.
- Stability: while wb_valid_o && !wb_ready_i, wb_trans_id_o and wb_result_o stay stable.
- Ordering: results are strictly FIFO.
- Counter arithmetic: count is CNT_W bits, unsigned. It takes +1 on a push only, -1 on a pop only, and is unchanged otherwise. Underflow is impossible by construction; this is asserted.

Decomposition:
- ariane_pkg gains typedef alu_wb_entry_t = struct {logic [TRANS_ID_BITS-1:0] trans_id; riscv::xlen_t result;}.
- The storage array is alu_wb_entry_t [DEPTH-1:0].
- No sub-module. Storage, pointers and counter stay inline, since the whole block is about 150 lines.
- Assertions: DEPTH is a power of two and at least 2; no push when full; no pop when empty; outputs stable under backpressure.

Test Plan:
- Reset, then a single push of trans_id=3, result=0x1234 with wb_ready_i=1 -> next cycle wb_valid_o=1, trans_id=3, result=0x1234. The following cycle wb_valid_o=0 and usage_o=0.
- With wb_ready_i=0, push trans_ids 0,1,2,3 (DEPTH=4) -> usage_o=4 and alu_ready_o=0. Raising wb_ready_i drains them in order 0,1,2,3 over 4 cycles, and alu_ready_o returns to 1 after the first pop.
- Full queue, with alu_valid_i=1 and wb_ready_i=1 in the same cycle -> pop occurs, push refused, usage_o=3.
- Continuous push and pop for 10 cycles with trans_id=i and result=i*0x10 -> usage_o stays 1, and outputs appear in order with 1-cycle latency across pointer wrap.
- Queue holding 3 entries, with flush_i=1 and alu_valid_i=1 in the same cycle -> next cycle usage_o=0, wb_valid_o=0, and the flushed-cycle result never appears.
- Queue holding 2 entries, then assert rst_ni=0 mid-stream -> wb_valid_o=0, usage_o=0 and alu_ready_o=1 immediately (asynchronous). After release, a push of trans_id=5 appears alone.

Source files
------------

// File: rtl/alu_wb_queue_pkg.sv
// Shared types for the ALU writeback queue slice of the execute stage:
// the functional-unit operation bundle and the queued writeback entry.
package alu_wb_queue_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned NR_SB_ENTRIES = 16;
    localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

    typedef logic [XLEN-1:0] xlen_t;

    typedef enum logic [2:0] {
        FU_NONE,
        FU_ALU,
        FU_BRANCH,
        FU_LOAD,
        FU_STORE,
        FU_MULT,
        FU_CSR
    } fu_t;

    typedef struct packed {
        fu_t                      fu;
        logic [7:0]               operation;
        xlen_t                    operand_a;
        xlen_t                    operand_b;
        xlen_t                    imm;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } fu_data_t;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        xlen_t                    result;
    } alu_wb_entry_t;

endpackage

// File: rtl/alu_wb_queue_if.sv
// ALU result input and scoreboard writeback output of the ALU writeback
// queue. The slave modport is the queue itself; master is its environment.
interface alu_wb_queue_if;
    import alu_wb_queue_pkg::*;

    logic                     alu_valid_i;
    logic                     alu_ready_o;
    fu_data_t                 fu_data_i;
    xlen_t                    alu_result_i;
    logic                     wb_valid_o;
    logic                     wb_ready_i;
    logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
    xlen_t                    wb_result_o;

    modport slave (
        input  alu_valid_i,
        input  fu_data_i,
        input  alu_result_i,
        input  wb_ready_i,
        output alu_ready_o,
        output wb_valid_o,
        output wb_trans_id_o,
        output wb_result_o
    );

    modport master (
        output alu_valid_i,
        output fu_data_i,
        output alu_result_i,
        output wb_ready_i,
        input  alu_ready_o,
        input  wb_valid_o,
        input  wb_trans_id_o,
        input  wb_result_o
    );

endinterface

// File: rtl/alu_wb_queue.sv
// In-order queue between the non-stallable ALU and the scoreboard
// writeback port. Full/empty come only from the occupancy counter; the
// head entry is read straight from storage, so there is no bypass and no
// combinational path from any input to any output.
module alu_wb_queue
    import alu_wb_queue_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    // Allows directed tests to drive deliberate overflow without tripping
    // the upstream protocol check.
    parameter bit          OVERFLOW_CHECK = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    alu_wb_queue_if.slave          alu_if,
    output logic [$clog2(DEPTH):0] usage_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("alu_wb_queue: DEPTH must be a power of two and at least 2");
    end

    alu_wb_entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [PTR_W-1:0]          wr_ptr_q;
    logic [CNT_W-1:0]          count_q;
    logic                      push;
    logic                      pop;
    logic                      unused_fu_data;

    assign alu_if.alu_ready_o   = (count_q != CNT_W'(DEPTH));
    assign alu_if.wb_valid_o    = (count_q != '0);
    assign alu_if.wb_trans_id_o = mem_q[rd_ptr_q].trans_id;
    assign alu_if.wb_result_o   = mem_q[rd_ptr_q].result;
    assign usage_o              = count_q;

    assign push = alu_if.alu_valid_i && alu_if.alu_ready_o;
    assign pop  = alu_if.wb_valid_o && alu_if.wb_ready_i;

    // Only trans_id of the operation bundle is carried with the result.
    assign unused_fu_data = ^{alu_if.fu_data_i.fu, alu_if.fu_data_i.operation,
                              alu_if.fu_data_i.operand_a, alu_if.fu_data_i.operand_b,
                              alu_if.fu_data_i.imm};

    // Storage, pointers and occupancy; flush overrides any push/pop of the cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q].trans_id <= alu_if.fu_data_i.trans_id;
                mem_q[wr_ptr_q].result   <= alu_if.alu_result_i;
                wr_ptr_q                 <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

`ifndef SYNTHESIS
    if (OVERFLOW_CHECK) begin : g_overflow_check
        a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (alu_if.alu_valid_i && !flush_i) |-> alu_if.alu_ready_o)
            else $error("alu_wb_queue: ALU result dropped, queue full");
    end

    a_no_pop_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop |-> (count_q != '0));

    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (pop && !push) |-> (count_q != '0));

    a_stable_under_backpressure: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (alu_if.wb_valid_o && !alu_if.wb_ready_i && !flush_i)
            |=> ($stable(alu_if.wb_trans_id_o) && $stable(alu_if.wb_result_o)));
`endif

endmodule

// File: tb/tb_alu_wb_queue.sv
// Directed bench for alu_wb_queue with DEPTH=4: single push, fill/drain,
// refused push when full, streaming across pointer wrap, flush and
// asynchronous reset mid-stream.
module tb_alu_wb_queue;
    import alu_wb_queue_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [2:0] usage;
    int         passes;
    int         total;

    alu_wb_queue_if bus ();

    alu_wb_queue #(
        .DEPTH          (4),
        .OVERFLOW_CHECK (1'b0)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .alu_if  (bus.slave),
        .usage_o (usage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive_push(input logic [3:0] tid, input logic [63:0] res);
        bus.alu_valid_i        = 1'b1;
        bus.fu_data_i          = '0;
        bus.fu_data_i.fu       = FU_ALU;
        bus.fu_data_i.trans_id = tid;
        bus.alu_result_i       = res;
    endtask

    task automatic idle();
        bus.alu_valid_i  = 1'b0;
        bus.fu_data_i    = '0;
        bus.alu_result_i = '0;
    endtask

    task automatic chk_head(input string tag, input int tid, input logic [63:0] res);
        chk({tag, "_valid"}, 64'(bus.wb_valid_o), 64'd1);
        chk({tag, "_tid"}, 64'(bus.wb_trans_id_o), 64'(tid));
        chk({tag, "_res"}, bus.wb_result_o, res);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, 64'(bus.wb_valid_o), 64'd0);
        chk({tag, "_usage"}, 64'(usage), 64'd0);
        chk({tag, "_ready"}, 64'(bus.alu_ready_o), 64'd1);
    endtask

    initial begin
        passes         = 0;
        total          = 0;
        rst_n          = 1'b0;
        flush          = 1'b0;
        bus.wb_ready_i = 1'b0;
        idle();

        // Reset state
        tick();
        tick();
        chk_empty("rst");
        chk("rst_tid", 64'(bus.wb_trans_id_o), 64'd0);
        chk("rst_res", bus.wb_result_o, 64'd0);
        rst_n = 1'b1;

        // Single push visible next cycle, consumed the cycle after
        bus.wb_ready_i = 1'b1;
        drive_push(4'd3, 64'h1234);
        tick();
        idle();
        chk_head("single", 3, 64'h1234);
        chk("single_usage", 64'(usage), 64'd1);
        tick();
        chk_empty("single_drained");

        // Fill under backpressure, then drain in order
        bus.wb_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_push(4'(i), 64'h100 + 64'(i));
            tick();
        end
        idle();
        chk("fill_usage", 64'(usage), 64'd4);
        chk("fill_ready", 64'(bus.alu_ready_o), 64'd0);
        chk_head("fill_head_held", 0, 64'h100);
        bus.wb_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_head("drain", i, 64'h100 + 64'(i));
            tick();
            if (i == 0) chk("drain_ready_after_first", 64'(bus.alu_ready_o), 64'd1);
        end
        chk_empty("drain_done");

        // Full queue: push refused while the head pops
        bus.wb_ready_i = 1'b0;
        for (int i = 8; i < 12; i++) begin
            drive_push(4'(i), 64'h200 + 64'(i));
            tick();
        end
        drive_push(4'd12, 64'hDEAD);
        bus.wb_ready_i = 1'b1;
        tick();
        idle();
        bus.wb_ready_i = 1'b0;
        chk("full_usage", 64'(usage), 64'd3);
        chk_head("full_head", 9, 64'h209);
        bus.wb_ready_i = 1'b1;
        for (int i = 9; i < 12; i++) begin
            chk_head("full_drain", i, 64'h200 + 64'(i));
            tick();
        end
        chk_empty("full_refused_gone");

        // Streaming push+pop across pointer wrap
        for (int i = 0; i < 10; i++) begin
            drive_push(4'(i), 64'(i) * 64'h10);
            tick();
            chk("stream_usage", 64'(usage), 64'd1);
            chk_head("stream", i, 64'(i) * 64'h10);
        end
        idle();
        tick();
        chk_empty("stream_done");

        // Flush with a simultaneous push
        bus.wb_ready_i = 1'b0;
        for (int i = 1; i < 4; i++) begin
            drive_push(4'(i), 64'h30 + 64'(i));
            tick();
        end
        chk("preflush_usage", 64'(usage), 64'd3);
        flush = 1'b1;
        drive_push(4'd7, 64'h777);
        tick();
        flush = 1'b0;
        idle();
        chk_empty("flush");
        drive_push(4'd4, 64'h44);
        tick();
        idle();
        chk("postflush_usage", 64'(usage), 64'd1);
        chk_head("postflush", 4, 64'h44);
        bus.wb_ready_i = 1'b1;
        tick();
        chk_empty("postflush_drained");

        // Asynchronous reset mid-stream
        bus.wb_ready_i = 1'b0;
        drive_push(4'd1, 64'h11);
        tick();
        drive_push(4'd2, 64'h22);
        tick();
        idle();
        chk("prereset_usage", 64'(usage), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_empty("async_rst");
        chk("async_rst_tid", 64'(bus.wb_trans_id_o), 64'd0);
        chk("async_rst_res", bus.wb_result_o, 64'd0);
        tick();
        rst_n = 1'b1;
        drive_push(4'd5, 64'h55);
        tick();
        idle();
        chk("postrst_usage", 64'(usage), 64'd1);
        chk_head("postrst", 5, 64'h55);
        bus.wb_ready_i = 1'b1;
        tick();
        chk_empty("postrst_drained");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
